// File: rtl/quad_pkg.sv
// Shared types and Gray-code phase tables for the quadrature decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} quad_state_t;
    typedef logic [1:0] phase_t;
    typedef enum logic [1:0] {MV_NONE, MV_FWD, MV_REV, MV_ILL} move_t;

    // Indexed by current phase: forward successor and reverse successor
    localparam logic [3:0][1:0] FWD = {2'b10, 2'b00, 2'b11, 2'b01};
    localparam logic [3:0][1:0] REV = {2'b01, 2'b11, 2'b00, 2'b10};

    function automatic move_t decode(phase_t prev, phase_t cur);
        if (cur == prev)      return MV_NONE;
        if (cur == FWD[prev]) return MV_FWD;
        if (cur == REV[prev]) return MV_REV;
        return MV_ILL;
    endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder pins, control strobes and position outputs of the quadrature decoder.
interface quad_decoder_if #(parameter int SIZE = 4);
    logic            a_in;
    logic            b_in;
    logic            clr;
    logic            err_clr;
    logic [SIZE-1:0] count;
    logic            dir;
    logic            step;
    logic            err;

    modport master (output a_in, b_in, clr, err_clr, input count, dir, step, err);
    modport slave  (input a_in, b_in, clr, err_clr, output count, dir, step, err);
endinterface

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a level filter that accepts a new level
// only after it has been seen FILT consecutive cycles.
module quad_filter #(
    parameter int FILT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl
);

    logic       sync1, sync2;
    logic [3:0] run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl   <= 1'b0;
            run   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != lvl) begin
                if (run == 4'(FILT - 1)) begin
                    lvl <= ~lvl;
                    run <= '0;
                end else begin
                    run <= run + 4'd1;
                end
            end else begin
                run <= '0;
            end
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: filtered A/B phases drive a Gray-order step decoder and
// a wrapping up/down position counter with a sticky illegal-jump flag.
import quad_pkg::*;

module quad_decoder #(
    parameter int SIZE = 4,
    parameter int FILT = 2
) (
    input  logic           clk,
    input  logic           rst,
    quad_decoder_if.slave  bus
);

    phase_t          raw, p;
    quad_state_t     state_q, state_d;
    phase_t          prev_q, prev_d;
    logic [SIZE-1:0] count_q, count_d;
    logic            dir_q, dir_d, step_q, step_d, err_q, err_d;
    move_t           mv;

    assign raw = {bus.a_in, bus.b_in};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        quad_filter #(.FILT(FILT)) u_filt (
            .clk (clk),
            .rst (rst),
            .raw (raw[i]),
            .lvl (p[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            prev_q  <= '0;
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        mv      = MV_NONE;
        // INIT adopts whatever phase is present so a non-zero start is not a step
        unique case (state_q)
            INIT: begin
                prev_d  = p;
                state_d = TRACK;
            end
            TRACK: begin
                prev_d = p;
                mv     = decode(prev_q, p);
            end
            default: state_d = INIT;
        endcase
        case (mv)
            MV_FWD: begin
                count_d = count_q + SIZE'(1);
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end
            MV_REV: begin
                count_d = count_q - SIZE'(1);
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end
            default: ;
        endcase
        // clr wins over a coincident step; prev tracking is unaffected
        if (bus.clr) begin
            count_d = '0;
            dir_d   = dir_q;
            step_d  = 1'b0;
        end
        err_d = (mv == MV_ILL) | (err_q & ~bus.err_clr);
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed plus random stimulus for quad_decoder, checked every cycle against
// a cycle-level behavioural model using Gray-index arithmetic.
module tb_quad_decoder;

    localparam int SIZE = 4;
    localparam int FILT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_decoder_if #(.SIZE(SIZE)) qif ();

    quad_decoder #(.SIZE(SIZE), .FILT(FILT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (qif.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int nsteps = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Gray phase -> position index 0..3 along the forward order 00,01,11,10
    function automatic int gidx(input logic [1:0] ph);
        return {30'd0, ph[1], ph[1] ^ ph[0]};
    endfunction

    function automatic logic [1:0] gph(input int i);
        int j;
        j = i & 3;
        return {j[1], j[1] ^ j[0]};
    endfunction

    function automatic int delta(input logic [1:0] from, input logic [1:0] to);
        return (gidx(to) - gidx(from)) & 3;
    endfunction

    // ---------------- reference model ----------------
    logic [1:0]      m_s1, m_s2, m_lvl, m_prev;
    int              m_run [2];
    logic            m_init;
    logic [SIZE-1:0] m_count;
    logic            m_dir, m_step, m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_prev <= '0;
            m_run[0] <= 0; m_run[1] <= 0;
            m_init <= 1'b1;
            m_count <= '0; m_dir <= 1'b1; m_step <= 1'b0; m_err <= 1'b0;
        end else begin
            m_s1 <= {qif.a_in, qif.b_in};
            m_s2 <= m_s1;
            for (int i = 0; i < 2; i++) begin
                if (m_s2[i] != m_lvl[i]) begin
                    if (m_run[i] + 1 >= FILT) begin
                        m_lvl[i] <= ~m_lvl[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end else begin
                    m_run[i] <= 0;
                end
            end
            m_prev <= m_lvl;
            if (m_init) begin
                m_init <= 1'b0;
                m_step <= 1'b0;
                if (qif.clr) m_count <= '0;
                m_err <= m_err && !qif.err_clr;
            end else begin
                if (qif.clr)                       m_count <= '0;
                else if (delta(m_prev, m_lvl) == 1) m_count <= m_count + 4'd1;
                else if (delta(m_prev, m_lvl) == 3) m_count <= m_count - 4'd1;
                m_step <= !qif.clr && (delta(m_prev, m_lvl) == 1 || delta(m_prev, m_lvl) == 3);
                if (!qif.clr && delta(m_prev, m_lvl) == 1) m_dir <= 1'b1;
                if (!qif.clr && delta(m_prev, m_lvl) == 3) m_dir <= 1'b0;
                m_err <= (delta(m_prev, m_lvl) == 2) || (m_err && !qif.err_clr);
            end
        end
    end

    always @(negedge clk) begin
        chk("count", 32'(qif.count), 32'(m_count));
        chk("dir",   32'(qif.dir),   32'(m_dir));
        chk("step",  32'(qif.step),  32'(m_step));
        chk("err",   32'(qif.err),   32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset(input logic [1:0] ph);
        @(negedge clk);
        #2;
        rst = 1'b0;
        qif.a_in = ph[1]; qif.b_in = ph[0];
        qif.clr = 1'b0; qif.err_clr = 1'b0;
        #1;
        chk("rst_count", 32'(qif.count), 32'd0);
        chk("rst_dir",   32'(qif.dir),   32'd1);
        chk("rst_step",  32'(qif.step),  32'd0);
        chk("rst_err",   32'(qif.err),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Drive a phase and hold it n cycles; first = cycle index of first step seen
    task automatic apply(input logic [1:0] ph, input int n, output int first);
        qif.a_in = ph[1]; qif.b_in = ph[0];
        first = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (qif.step) begin
                nsteps++;
                if (first == 0) first = i;
            end
        end
    endtask

    int         f, s0;
    logic [1:0] ph;

    initial begin
        qif.a_in = 1'b0; qif.b_in = 1'b0; qif.clr = 1'b0; qif.err_clr = 1'b0;
        #1 rst = 1'b0;

        // non-zero start phase held through reset
        do_reset(2'b11);
        nsteps = 0;
        apply(2'b11, 10, f);
        chk("init_count", 32'(qif.count), 32'd0);
        chk("init_steps", 32'(nsteps), 32'd0);

        // forward 5 revolutions, checking latency of every step
        do_reset(2'b00);
        nsteps = 0;
        for (int r = 0; r < 20; r++) begin
            apply(gph(r + 1), 8, f);
            chk("fwd_lat", 32'(f), 32'd5);
        end
        chk("fwd_steps", 32'(nsteps), 32'd20);
        chk("fwd_count", 32'(qif.count), 32'd4);
        chk("fwd_dir",   32'(qif.dir),   32'd1);

        // reverse from zero with wrap
        do_reset(2'b00);
        apply(2'b10, 8, f); chk("rev_c15", 32'(qif.count), 32'd15);
        apply(2'b11, 8, f); chk("rev_c14", 32'(qif.count), 32'd14);
        apply(2'b01, 8, f); chk("rev_c13", 32'(qif.count), 32'd13);
        chk("rev_dir", 32'(qif.dir), 32'd0);

        // glitch rejection, then a minimum-length pulse
        s0 = nsteps;
        apply(2'b11, 1, f);
        apply(2'b01, 8, f);
        chk("glitch_steps", 32'(nsteps - s0), 32'd0);
        chk("glitch_count", 32'(qif.count), 32'd13);
        apply(2'b11, 2, f);
        apply(2'b01, 10, f);
        chk("pulse2_steps", 32'(nsteps - s0), 32'd2);
        chk("pulse2_count", 32'(qif.count), 32'd13);

        // illegal jumps and err_clr priority
        apply(2'b00, 8, f);
        apply(2'b11, 8, f);
        chk("ill_err",   32'(qif.err),   32'd1);
        chk("ill_count", 32'(qif.count), 32'd12);
        apply(2'b01, 8, f);
        qif.a_in = 1'b1; qif.b_in = 1'b0;
        repeat (4) @(negedge clk);
        qif.err_clr = 1'b1;
        @(negedge clk);
        chk("errclr_coinc", 32'(qif.err),   32'd1);
        chk("errclr_count", 32'(qif.count), 32'd11);
        @(negedge clk);
        qif.err_clr = 1'b0;
        chk("errclr_alone", 32'(qif.err), 32'd0);
        apply(2'b10, 4, f);

        // clr coincident with a step at count 7
        do_reset(2'b00);
        for (int r = 1; r <= 7; r++) apply(gph(r), 8, f);
        chk("pre_clr_count", 32'(qif.count), 32'd7);
        qif.a_in = 1'b0; qif.b_in = 1'b0;
        repeat (4) @(negedge clk);
        qif.clr = 1'b1;
        @(negedge clk);
        qif.clr = 1'b0;
        chk("clr_count", 32'(qif.count), 32'd0);
        chk("clr_step",  32'(qif.step),  32'd0);
        chk("clr_dir",   32'(qif.dir),   32'd1);
        apply(2'b00, 4, f);

        // asynchronous reset mid-sequence, then resume
        apply(2'b01, 8, f);
        apply(2'b11, 8, f);
        chk("pre_rst_count", 32'(qif.count), 32'd2);
        qif.a_in = 1'b1; qif.b_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(qif.count), 32'd0);
        chk("mid_rst_dir",   32'(qif.dir),   32'd1);
        chk("mid_rst_step",  32'(qif.step),  32'd0);
        chk("mid_rst_err",   32'(qif.err),   32'd0);
        qif.a_in = 1'b0; qif.b_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 1; r <= 4; r++) apply(gph(r), 8, f);
        chk("resume_count", 32'(qif.count), 32'd4);

        // random walk with glitches, illegal jumps and random clears
        do_reset(2'b00);
        ph = 2'b00;
        for (int it = 0; it < 60; it++) begin
            int r, hold;
            r    = $urandom_range(0, 9);
            hold = $urandom_range(3, 8);
            if (r < 3)       ph = gph(gidx(ph) + 1);
            else if (r < 6)  ph = gph(gidx(ph) + 3);
            else if (r == 6) ph = ph ^ 2'b11;
            else if (r == 7) apply(ph ^ 2'b10, 1, f);
            qif.clr     = ($urandom_range(0, 9) == 0);
            qif.err_clr = ($urandom_range(0, 5) == 0);
            apply(ph, 1, f);
            qif.clr = 1'b0; qif.err_clr = 1'b0;
            apply(ph, hold, f);
        end
        apply(ph, 8, f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that converts the two-phase A/B signals of an incremental encoder into up/down step events. It tracks position in a wrapping SIZE-bit up/down counter, with the same count semantics as our existing up/down counter. It sits between the encoder pins and the position/motor-control logic. Raw inputs are asynchronous: it synchronises them, glitch-filters them, and flags illegal phase jumps.

## Interface
- SIZE, 4, position counter width in bits
- FILT, 2, consecutive stable cycles required to accept a new input level (legal range 1..15)

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous reset, active-low
- a_in  in  1  encoder phase A, asynchronous to clk
- b_in  in  1  encoder phase B, asynchronous to clk
- clr  in  1  synchronous clear of count
- err_clr  in  1  synchronous clear of err
- count  out  SIZE  position, modulo 2^SIZE
- dir  out  1  direction of last accepted step, 1 = up, 0 = down
- step  out  1  one-cycle pulse per accepted step
- err  out  1  sticky illegal-transition flag

## Operation
- Each input passes through a 2-flop synchroniser, then a level filter.
- Filter behaviour:
  - Keeps a filtered level and a run counter.
  - When the sync output differs from the filtered level for FILT consecutive cycles, the filtered level flips.
  - Any return to the filtered level resets the run counter.
  - Pulses shorter than FILT cycles are rejected.
- Phase p = {a_f, b_f}. Forward Gray order: 00→01→11→10→00.
- FSM states:
  - INIT: entered on reset. On the first cycle after reset release, prev ← p and the FSM moves to TRACK. No step and no err are produced in this state.
  - TRACK: each cycle p ≠ prev is decoded:
    - Forward neighbour: count+1, dir=1, step=1.
    - Reverse neighbour: count−1, dir=0, step=1.
    - Both bits changed: err←1, count, dir and step unchanged.
    - In all three cases prev ← p.
- Wrap-around: 2^SIZE−1 +1 → 0; 0 −1 → 2^SIZE−1. No saturation.
- Priority rules:
  - clr and a step in the same cycle: count←0, step=0, dir unchanged, prev still updated.
  - err_clr and a new illegal transition in the same cycle: err stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), then INIT re-runs.

## Timing
- Reset values:
  - count=0, dir=1, step=0, err=0.
  - Sync flops, filtered levels and prev = 0; run counters = 0; state = INIT.
- Latency, for an input change first sampled at edge k:
  - sync2 holds the new value after edge k+1.
  - Filtered level flips at edge k+1+FILT.
  - count, dir and step update at edge k+2+FILT (k+4 with FILT=2).
- step is high for exactly one cycle per accepted step.
- Maximum step rate: one count per FILT+1 cycles per phase edge. Faster inputs may produce err.
- clr and err_clr take effect at the next edge (one-cycle latency) and have no reset-like asynchronous path.

## Structure
- Package quad_pkg contains:
  - typedef enum logic {INIT, TRACK} quad_state_t
  - typedef logic [1:0] phase_t
  - localparams FWD/REV encoding the Gray successor table
  - a function returning step direction/illegal for a (prev, cur) pair
- Sub-module quad_filter (synchroniser + level filter, parameter FILT), instantiated once each for A and B.
- Top module contains the FSM, the decode and the counter.

## Test plan
- Reset with a_in=b_in=1, release, hold 10 cycles → count=0, step never pulses, err=0 (INIT absorbs the non-zero start phase).
- Forward sequence 00→01→11→10→00 repeated 5 times, 8 cycles per phase, FILT=2 → 20 step pulses, count wraps 15→0 and ends at 4, dir=1; each update lands exactly 4 edges after the input change.
- Reverse sequence from count=0, 3 phases → count=15, 14, 13, dir=0.
- 1-cycle glitch on a_in (FILT=2) → no filtered change, no step, count unchanged. 2-cycle stable change → one step.
- Phase 00→11 directly → err=1, count unchanged. Assert err_clr in the same cycle as a second 01→10 jump → err stays 1. err_clr alone the next cycle → err=0.
- clr coincident with a forward step at count=7 → count=0, step=0. Assert rst mid-sequence → outputs return to reset values immediately, and counting resumes correctly after release.
